letc_core_stub_imss: RTL

- Synthesizable stub instruction memory subsystem; sits directly upstream of the core's fetch stage in stubmss builds and replaces the AXI-backed IMSS.
- Holds a word-addressed ROM array `imem`, preloaded by the bench via hierarchical `$readmemh`.
- Serves in-order fetch requests with configurable latency, bounded outstanding requests, optional random backpressure and flush on redirect.

---
 rtl/letc_core_stub_imss_pkg.sv | 25 ++
 rtl/letc_core_stub_imss_if.sv | 25 ++
 rtl/letc_core_stub_imss_rspq.sv | 76 +++++++
 rtl/letc_core_stub_imss.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/letc_core_stub_imss_pkg.sv
// Shared types for the stub instruction memory subsystem: fault codes,
// the response record carried through the delay line and queue, and
// the stall LFSR feedback mask.
package letc_core_pkg;

    typedef enum logic [1:0] {
        IMSS_FAULT_NONE       = 2'd0,
        IMSS_FAULT_MISALIGNED = 2'd1,
        IMSS_FAULT_ACCESS     = 2'd2
    } imss_fault_e;

    typedef struct packed {
        logic [31:0] instr;
        imss_fault_e fault;
    } imss_rsp_s;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
    localparam logic [15:0] IMSS_STALL_LFSR_TAPS = 16'h002D;

    // One LFSR step: feedback enters at bit 15, state shifts toward bit 0.
    function automatic logic [15:0] imss_lfsr_next(input logic [15:0] s);
        return {^(s & IMSS_STALL_LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/letc_core_stub_imss_if.sv
// Fetch request/response bundle between the core fetch stage (master)
// and the stub IMSS (slave).
interface letc_core_stub_imss_if;
    import letc_core_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    imss_fault_e rsp_fault;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );

endinterface

// File: rtl/letc_core_stub_imss_rspq.sv
// In-order response queue. The head is read straight out of the storage
// registers, so the visible response is always a registered value.
// A flush empties the queue; a push on the same edge becomes the sole entry.
module letc_core_stub_imss_rspq
    import letc_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  imss_rsp_s                    push_data,
    input  logic                         pop,
    input  logic                         flush,
    output imss_rsp_s                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    imss_rsp_s         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next pointers and occupancy; flush rewinds both pointers to slot 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_addr  = wr_ptr_q;
        if (flush) begin
            wr_addr  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = push ? ptr_inc('0) : '0;
            count_d  = push ? CW'(1) : '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; data is never reset, only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_addr] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/letc_core_stub_imss.sv
// Stub instruction memory subsystem: word-addressed ROM with request decode,
// a configurable delay line, bounded outstanding requests, optional
// LFSR-driven request backpressure and flush on redirect.
module letc_core_stub_imss
    import letc_core_pkg::*;
#(
    parameter int          DEPTH_WORDS     = 16384,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter bit          STALL_EN        = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    letc_core_stub_imss_if.slave  bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(DEPTH_WORDS);

    // Preloaded by the environment; never written or reset by this block.
    logic [31:0] imem [DEPTH_WORDS];

    logic [15:0]   lfsr_q, lfsr_d;
    logic [OW-1:0] outstanding_q, outstanding_d;

    logic          req_ready_w;
    logic          accept;
    logic          pop;
    logic          rsp_valid_w;
    logic [31:0]   off;
    logic [31:0]   word;
    imss_rsp_s     dec_rsp;

    logic          q_push;
    imss_rsp_s     q_push_data;
    imss_rsp_s     q_head;
    logic [OW-1:0] q_count;
    logic          q_empty;
    logic          q_full;

    // Ready comes only from registered state, never from req_valid or rsp_ready.
    assign req_ready_w = rst_n && (outstanding_q < OW'(MAX_OUTSTANDING))
                         && !(STALL_EN && lfsr_q[0]);
    assign accept      = bus.req_valid && req_ready_w;
    assign rsp_valid_w = rst_n && !q_empty;
    assign pop         = rsp_valid_w && bus.rsp_ready;

    // Address decode and ROM read; misalignment outranks the range check.
    always_comb begin
        off           = bus.req_addr - BASE_ADDR;
        word          = off >> 2;
        dec_rsp.instr = '0;
        dec_rsp.fault = IMSS_FAULT_NONE;
        if (bus.req_addr[1:0] != 2'b00) begin
            dec_rsp.fault = IMSS_FAULT_MISALIGNED;
        end else if (word >= 32'(DEPTH_WORDS)) begin
            dec_rsp.fault = IMSS_FAULT_ACCESS;
        end else begin
            dec_rsp.instr = imem[word[IW-1:0]];
        end
    end

    if (LATENCY == 1) begin : g_direct
        // The accept edge writes the decoded response straight into the queue.
        assign q_push      = accept;
        assign q_push_data = dec_rsp;
    end else begin : g_dly
        logic      dly_vld_q [LATENCY-1];
        logic      dly_vld_d [LATENCY-1];
        imss_rsp_s dly_rsp_q [LATENCY-1];
        imss_rsp_s dly_rsp_d [LATENCY-1];

        // Shift the delay line; flush kills everything except the new accept.
        always_comb begin
            dly_vld_d[0] = accept;
            dly_rsp_d[0] = dec_rsp;
            for (int i = 1; i < LATENCY - 1; i++) begin
                dly_vld_d[i] = bus.flush ? 1'b0 : dly_vld_q[i-1];
                dly_rsp_d[i] = dly_rsp_q[i-1];
            end
        end

        // Delay-line valids carry reset; payloads do not.
        always_ff @(posedge clk) begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                dly_vld_q[i] <= rst_n ? dly_vld_d[i] : 1'b0;
                dly_rsp_q[i] <= dly_rsp_d[i];
            end
        end

        assign q_push      = dly_vld_q[LATENCY-2] && !bus.flush;
        assign q_push_data = dly_rsp_q[LATENCY-2];
    end

    letc_core_stub_imss_rspq #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rspq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (pop),
        .flush     (bus.flush),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Outstanding count and stall LFSR next-state.
    always_comb begin
        outstanding_d = outstanding_q;
        lfsr_d        = imss_lfsr_next(lfsr_q);
        if (bus.flush) begin
            outstanding_d = accept ? OW'(1) : '0;
        end else if (accept && !pop) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!accept && pop) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    // Control registers: outstanding count and LFSR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            outstanding_q <= outstanding_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_instr = rsp_valid_w ? q_head.instr : 32'h0;
    assign bus.rsp_fault = rsp_valid_w ? q_head.fault : IMSS_FAULT_NONE;

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk)
        LATENCY >= 1 && LATENCY <= 4 &&
        MAX_OUTSTANDING >= 1 && MAX_OUTSTANDING <= 8 &&
        LFSR_SEED != 16'h0000);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (q_push && !bus.flush) |-> !q_full);
    a_queue_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        q_count <= outstanding_q);
`endif

endmodule
